// File: rtl/cavlc_scan_stat_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : cavlc_scan_stat_pkg                                              |
// | Brief    : Shared constants, accumulator types and per-coefficient update.  |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
package cavlc_scan_stat_pkg;

    localparam int COEFF_W = 16;

    localparam logic [3:0] c_SCAN_INIT   = 4'd0;
    localparam logic [3:0] c_SCAN_CYCLE0 = 4'd1;
    localparam logic [3:0] c_SCAN_CYCLE7 = 4'd8;

    typedef struct packed {
        logic [4:0] cnt;
        logic [3:0] zc;
        logic [3:0] tz;
        logic [1:0] t1;
        logic       t1_open;
        logic [2:0] t1_sign;
    } acc_t;

    localparam acc_t c_ACC_START = '{cnt: 5'd0, zc: 4'd0, tz: 4'd0, t1: 2'd0,
                                     t1_open: 1'b1, t1_sign: 3'd0};

    typedef struct packed {
        acc_t       acc;
        logic       lvl_we;
        logic [3:0] lvl_idx;
        logic       run_we;
        logic [3:0] run_idx;
        logic [3:0] run_val;
    } step_t;

    // One coefficient of the reverse zig-zag walk; the pending zero count
    // becomes the run_before of the previously seen nonzero.
    function automatic step_t step_coeff(input acc_t acc_in, input logic [COEFF_W-1:0] coeff);
        step_t v_res;
        logic  v_unit;
        v_res     = '0;
        v_res.acc = acc_in;
        v_unit    = (coeff == COEFF_W'(1)) || (coeff == {COEFF_W{1'b1}});
        if (coeff != '0) begin
            v_res.lvl_we  = 1'b1;
            v_res.lvl_idx = acc_in.cnt[3:0];
            v_res.run_we  = (acc_in.cnt != 5'd0);
            v_res.run_idx = acc_in.cnt[3:0] - 4'd1;
            v_res.run_val = acc_in.zc;
            v_res.acc.zc  = 4'd0;
            if (acc_in.cnt != 5'd16) begin
                v_res.acc.cnt = acc_in.cnt + 5'd1;
            end
            if (acc_in.t1_open && v_unit && (acc_in.t1 != 2'd3)) begin
                v_res.acc.t1_sign = acc_in.t1_sign | (3'(coeff[COEFF_W-1]) << acc_in.t1);
                v_res.acc.t1      = acc_in.t1 + 2'd1;
            end else begin
                v_res.acc.t1_open = 1'b0;
            end
        end else if (acc_in.cnt != 5'd0) begin
            v_res.acc.zc = acc_in.zc + 4'd1;
            v_res.acc.tz = acc_in.tz + 4'd1;
        end
        return v_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cavlc_scan_stat_pair.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : cavlc_pair_stat                                                  |
// | Brief    : Combinational update of the block accumulators by one pair.      |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module cavlc_pair_stat
    import cavlc_scan_stat_pkg::*;
(
    input  logic [4:0]         i_cnt,
    input  logic [3:0]         i_zc,
    input  logic [3:0]         i_tz,
    input  logic [1:0]         i_t1,
    input  logic               i_t1_open,
    input  logic [2:0]         i_t1_sign,
    input  logic [COEFF_W-1:0] i_coeff_a,
    input  logic [COEFF_W-1:0] i_coeff_b,
    input  logic               i_last,
    output logic [4:0]         o_cnt,
    output logic [3:0]         o_zc,
    output logic [3:0]         o_tz,
    output logic [1:0]         o_t1,
    output logic               o_t1_open,
    output logic [2:0]         o_t1_sign,
    output logic               o_lvl_we_a,
    output logic [3:0]         o_lvl_idx_a,
    output logic               o_lvl_we_b,
    output logic [3:0]         o_lvl_idx_b,
    output logic               o_run_we_a,
    output logic [3:0]         o_run_idx_a,
    output logic [3:0]         o_run_val_a,
    output logic               o_run_we_b,
    output logic [3:0]         o_run_idx_b,
    output logic [3:0]         o_run_val_b,
    output logic               o_fin_we,
    output logic [3:0]         o_fin_idx,
    output logic [3:0]         o_fin_val
);

    acc_t  w_acc_in;
    step_t w_step_a;
    step_t w_step_b;

    assign w_acc_in = {i_cnt, i_zc, i_tz, i_t1, i_t1_open, i_t1_sign};
    assign w_step_a = step_coeff(w_acc_in, i_coeff_a);
    assign w_step_b = step_coeff(w_step_a.acc, i_coeff_b);

    assign o_cnt      = w_step_b.acc.cnt;
    assign o_zc       = w_step_b.acc.zc;
    assign o_tz       = w_step_b.acc.tz;
    assign o_t1       = w_step_b.acc.t1;
    assign o_t1_open  = w_step_b.acc.t1_open;
    assign o_t1_sign  = w_step_b.acc.t1_sign;

    assign o_lvl_we_a  = w_step_a.lvl_we;
    assign o_lvl_idx_a = w_step_a.lvl_idx;
    assign o_lvl_we_b  = w_step_b.lvl_we;
    assign o_lvl_idx_b = w_step_b.lvl_idx;
    assign o_run_we_a  = w_step_a.run_we;
    assign o_run_idx_a = w_step_a.run_idx;
    assign o_run_val_a = w_step_a.run_val;
    assign o_run_we_b  = w_step_b.run_we;
    assign o_run_idx_b = w_step_b.run_idx;
    assign o_run_val_b = w_step_b.run_val;

    // Zeros left below the lowest-frequency nonzero; stored, never coded.
    assign o_fin_we  = i_last && (w_step_b.acc.cnt != 5'd0);
    assign o_fin_idx = w_step_b.acc.cnt[3:0] - 4'd1;
    assign o_fin_val = w_step_b.acc.zc;

endmodule
`default_nettype wire

// File: rtl/cavlc_scan_stat.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : cavlc_scan_stat                                                  |
// | Brief    : CAVLC coefficient statistics with ping-pong level/run buffer.    |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module cavlc_scan_stat
    import cavlc_scan_stat_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         scan_state,
    input  logic               ac_mode,
    input  logic [COEFF_W-1:0] coeff_a,
    input  logic [COEFF_W-1:0] coeff_b,
    output logic               stat_valid,
    output logic [4:0]         total_coeff,
    output logic [1:0]         trailing_ones,
    output logic [2:0]         t1_sign,
    output logic [3:0]         total_zeros,
    input  logic [3:0]         rd_addr,
    output logic [COEFF_W-1:0] rd_level,
    output logic [3:0]         rd_run
);

    acc_t               r_acc;
    logic               r_ac_mode;
    logic               r_wr_bank;
    logic               r_rd_bank;
    logic               r_stat_valid;
    logic [4:0]         r_total_coeff;
    logic [1:0]         r_trailing_ones;
    logic [2:0]         r_t1_sign;
    logic [3:0]         r_total_zeros;
    logic [COEFF_W-1:0] r_lvl [2][16];
    logic [3:0]         r_run [2][16];

    logic               w_scan;
    logic               w_first;
    logic               w_last;
    logic               w_ac;
    logic [COEFF_W-1:0] w_coeff_b;
    acc_t               w_acc_in;
    acc_t               w_acc_nxt;
    logic [4:0]         w_cnt;
    logic [3:0]         w_zc;
    logic [3:0]         w_tz;
    logic [1:0]         w_t1;
    logic               w_t1_open;
    logic [2:0]         w_t1_sign;
    logic               w_lvl_we_a, w_lvl_we_b;
    logic [3:0]         w_lvl_idx_a, w_lvl_idx_b;
    logic               w_run_we_a, w_run_we_b, w_fin_we;
    logic [3:0]         w_run_idx_a, w_run_idx_b, w_fin_idx;
    logic [3:0]         w_run_val_a, w_run_val_b, w_fin_val;

    // Encodings above scan_cycle7 fall outside this window and act as init.
    assign w_scan    = (scan_state >= c_SCAN_CYCLE0) && (scan_state <= c_SCAN_CYCLE7);
    assign w_first   = (scan_state == c_SCAN_CYCLE0);
    assign w_last    = (scan_state == c_SCAN_CYCLE7);
    assign w_ac      = w_first ? ac_mode : r_ac_mode;
    assign w_coeff_b = (w_last && w_ac) ? '0 : coeff_b;
    assign w_acc_in  = w_first ? c_ACC_START : r_acc;
    assign w_acc_nxt = {w_cnt, w_zc, w_tz, w_t1, w_t1_open, w_t1_sign};

    cavlc_pair_stat u_pair (
        .i_cnt       (w_acc_in.cnt),
        .i_zc        (w_acc_in.zc),
        .i_tz        (w_acc_in.tz),
        .i_t1        (w_acc_in.t1),
        .i_t1_open   (w_acc_in.t1_open),
        .i_t1_sign   (w_acc_in.t1_sign),
        .i_coeff_a   (coeff_a),
        .i_coeff_b   (w_coeff_b),
        .i_last      (w_last),
        .o_cnt       (w_cnt),
        .o_zc        (w_zc),
        .o_tz        (w_tz),
        .o_t1        (w_t1),
        .o_t1_open   (w_t1_open),
        .o_t1_sign   (w_t1_sign),
        .o_lvl_we_a  (w_lvl_we_a),
        .o_lvl_idx_a (w_lvl_idx_a),
        .o_lvl_we_b  (w_lvl_we_b),
        .o_lvl_idx_b (w_lvl_idx_b),
        .o_run_we_a  (w_run_we_a),
        .o_run_idx_a (w_run_idx_a),
        .o_run_val_a (w_run_val_a),
        .o_run_we_b  (w_run_we_b),
        .o_run_idx_b (w_run_idx_b),
        .o_run_val_b (w_run_val_b),
        .o_fin_we    (w_fin_we),
        .o_fin_idx   (w_fin_idx),
        .o_fin_val   (w_fin_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc           <= '0;
            r_ac_mode       <= 1'b0;
            r_wr_bank       <= 1'b0;
            r_rd_bank       <= 1'b0;
            r_stat_valid    <= 1'b0;
            r_total_coeff   <= 5'd0;
            r_trailing_ones <= 2'd0;
            r_t1_sign       <= 3'd0;
            r_total_zeros   <= 4'd0;
        end else begin
            r_stat_valid <= 1'b0;
            if (w_scan) begin
                r_acc <= w_acc_nxt;
            end
            if (w_first) begin
                r_ac_mode <= ac_mode;
            end
            if (w_last) begin
                r_stat_valid    <= 1'b1;
                r_total_coeff   <= w_acc_nxt.cnt;
                r_trailing_ones <= w_acc_nxt.t1;
                r_t1_sign       <= w_acc_nxt.t1_sign;
                r_total_zeros   <= w_acc_nxt.tz;
                r_rd_bank       <= r_wr_bank;
                r_wr_bank       <= ~r_wr_bank;
            end
        end
    end

    // Buffer contents carry no reset; only indices below total_coeff are meaningful.
    always_ff @(posedge clk) begin
        if (w_scan) begin
            if (w_lvl_we_a) r_lvl[r_wr_bank][w_lvl_idx_a] <= coeff_a;
            if (w_lvl_we_b) r_lvl[r_wr_bank][w_lvl_idx_b] <= w_coeff_b;
            if (w_run_we_a) r_run[r_wr_bank][w_run_idx_a] <= w_run_val_a;
            if (w_run_we_b) r_run[r_wr_bank][w_run_idx_b] <= w_run_val_b;
            if (w_fin_we)   r_run[r_wr_bank][w_fin_idx]   <= w_fin_val;
        end
    end

    assign stat_valid    = r_stat_valid;
    assign total_coeff   = r_total_coeff;
    assign trailing_ones = r_trailing_ones;
    assign t1_sign       = r_t1_sign;
    assign total_zeros   = r_total_zeros;
    assign rd_level      = r_lvl[r_rd_bank][rd_addr];
    assign rd_run        = r_run[r_rd_bank][rd_addr];

endmodule
`default_nettype wire

// File: tb/tb_cavlc_scan_stat.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_cavlc_scan_stat                                               |
// | Brief    : Scoreboard bench for cavlc_scan_stat against a positional model. |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module tb_cavlc_scan_stat;

    localparam int W = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [3:0]          scan_state;
    logic                ac_mode;
    logic signed [W-1:0] coeff_a;
    logic signed [W-1:0] coeff_b;
    logic                stat_valid;
    logic [4:0]          total_coeff;
    logic [1:0]          trailing_ones;
    logic [2:0]          t1_sign;
    logic [3:0]          total_zeros;
    logic [3:0]          rd_addr;
    logic signed [W-1:0] rd_level;
    logic [3:0]          rd_run;

    typedef struct {
        int tc;
        int t1;
        int sgn;
        int tz;
        int lv[16];
        int rn[16];
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   blk[16];

    cavlc_scan_stat dut (
        .clk           (clk),
        .rst           (rst),
        .scan_state    (scan_state),
        .ac_mode       (ac_mode),
        .coeff_a       (coeff_a),
        .coeff_b       (coeff_b),
        .stat_valid    (stat_valid),
        .total_coeff   (total_coeff),
        .trailing_ones (trailing_ones),
        .t1_sign       (t1_sign),
        .total_zeros   (total_zeros),
        .rd_addr       (rd_addr),
        .rd_level      (rd_level),
        .rd_run        (rd_run)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Statistics from positions of the nonzeros, walked high to low frequency.
    function automatic exp_t model(input bit ac);
        exp_t e;
        int   pos[$];
        int   v;
        e.tc = 0; e.t1 = 0; e.sgn = 0; e.tz = 0; e.cyc = 0;
        for (int i = 0; i < 16; i++) begin
            e.lv[i] = 0;
            e.rn[i] = 0;
        end
        for (int p = 15; p >= 0; p--) begin
            v = (ac && p == 0) ? 0 : blk[p];
            if (v != 0) begin
                e.lv[e.tc] = v;
                pos.push_back(p);
                e.tc++;
            end
        end
        for (int i = 0; i < e.tc && i < 3; i++) begin
            if (e.lv[i] != 1 && e.lv[i] != -1) break;
            if (e.lv[i] < 0) e.sgn = e.sgn | (1 << i);
            e.t1++;
        end
        if (e.tc > 0) e.tz = pos[0] + 1 - e.tc;
        for (int i = 0; i < e.tc; i++) begin
            if (i == e.tc - 1) e.rn[i] = pos[i];
            else               e.rn[i] = pos[i] - pos[i+1] - 1;
        end
        return e;
    endfunction

    task automatic fill_rand(input int zero_pct);
        for (int p = 0; p < 16; p++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < zero_pct)                 blk[p] = 0;
            else if (r < zero_pct + (100 - zero_pct) / 2)
                blk[p] = ($urandom_range(0, 1) == 1) ? 1 : -1;
            else                               blk[p] = int'($urandom_range(0, 600)) - 300;
        end
    endtask

    task automatic drive_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            scan_state = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15)) : 4'd0;
            ac_mode    = 1'($urandom);
            coeff_a    = W'($urandom);
            coeff_b    = W'($urandom);
        end
    endtask

    // stop_at = 8 sends a whole block; otherwise the block is cut at that cycle.
    task automatic send_block(input bit ac, input int stop_at, input bit use_rst);
        exp_t e;
        e = model(ac);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == stop_at) begin
                scan_state = use_rst ? 4'(k + 1) : 4'd0;
                rst        = use_rst;
                return;
            end
            scan_state = 4'(k + 1);
            ac_mode    = (k == 0) ? ac : 1'($urandom);
            coeff_a    = W'(blk[15 - 2*k]);
            coeff_b    = W'(blk[14 - 2*k]);
            if (k == 7) begin
                e.cyc = cyc + 1;
                exp_q.push_back(e);
            end
        end
    endtask

    initial begin
        exp_t e;
        int   idx;
        rd_addr = 4'd0;
        forever begin
            @(negedge clk);
            if (stat_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_stat_valid: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("stat_latency", cyc, e.cyc);
                    check("total_coeff", int'(total_coeff), e.tc);
                    check("trailing_ones", int'(trailing_ones), e.t1);
                    check("t1_sign", int'(t1_sign), e.sgn);
                    check("total_zeros", int'(total_zeros), e.tz);
                    for (int j = 0; j < 8; j++) begin
                        if (j > 0) begin
                            @(negedge clk);
                            check("valid_hold_low", int'(stat_valid), 0);
                        end
                        for (int h = 0; h < 2; h++) begin
                            idx = 2*j + h;
                            if (idx < e.tc) begin
                                rd_addr = 4'(idx);
                                #1;
                                check($sformatf("rd_level[%0d]", idx), int'(rd_level), e.lv[idx]);
                                check($sformatf("rd_run[%0d]", idx), int'(rd_run), e.rn[idx]);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        scan_state = 4'd0;
        ac_mode    = 1'b0;
        coeff_a    = '0;
        coeff_b    = '0;
        repeat (3) @(negedge clk);
        check("reset_stat_valid", int'(stat_valid), 0);
        check("reset_total_coeff", int'(total_coeff), 0);
        check("reset_trailing_ones", int'(trailing_ones), 0);
        check("reset_t1_sign", int'(t1_sign), 0);
        check("reset_total_zeros", int'(total_zeros), 0);
        rst = 1'b0;

        blk = '{0, 3, -1, 0, 0, -1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        send_block(1'b0, 8, 1'b0);
        drive_idle(10);

        blk = '{default: 0};
        send_block(1'b0, 8, 1'b0);
        drive_idle(10);

        blk = '{default: 2};
        send_block(1'b0, 8, 1'b0);
        drive_idle(10);

        blk = '{default: 0};
        blk[0] = 7;
        send_block(1'b1, 8, 1'b0);
        drive_idle(10);

        fill_rand(30);
        send_block(1'b0, 8, 1'b0);
        fill_rand(30);
        send_block(1'b0, 8, 1'b0);
        drive_idle(10);

        fill_rand(20);
        send_block(1'b0, 1, 1'b0);
        drive_idle(10);

        fill_rand(20);
        send_block(1'b0, 4, 1'b1);
        @(negedge clk);
        rst        = 1'b0;
        scan_state = 4'd0;
        check("midrst_stat_valid", int'(stat_valid), 0);
        check("midrst_total_coeff", int'(total_coeff), 0);
        check("midrst_trailing_ones", int'(trailing_ones), 0);
        check("midrst_t1_sign", int'(t1_sign), 0);
        check("midrst_total_zeros", int'(total_zeros), 0);
        drive_idle(10);

        fill_rand(40);
        send_block(1'b0, 8, 1'b0);
        drive_idle(10);

        for (int n = 0; n < 40; n++) begin
            fill_rand(int'($urandom_range(0, 90)));
            send_block(1'($urandom_range(0, 3) == 0), 8, 1'b0);
            drive_idle(int'($urandom_range(0, 3)));
        end
        drive_idle(2);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        repeat (10) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
